// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan display.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_ITER   = 8;

  // Segment patterns ordered {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal nibbles never reach here in normal use; show them as blank
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, BCD_ITER steps per conversion.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam logic [3:0] LAST_ITER = 4'(BCD_ITER - 1);

  logic [7:0]  shift_q;
  logic [11:0] bcd_q;
  logic [3:0]  iter_q;
  logic        active_q;
  logic [11:0] bcd_adj;

  // Add 3 to every nibble that would overflow past 9 after the coming shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // done marks the edge that performs the final iteration
  assign done     = active_q && (iter_q == LAST_ITER);
  assign busy     = active_q;
  assign hundreds = bcd_q[11:8];
  assign tens     = bcd_q[7:4];
  assign ones     = bcd_q[3:0];

  // Load on start, then shift the binary MSB into the adjusted BCD each cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      active_q <= 1'b0;
    end else if (abort) begin
      active_q <= 1'b0;
    end else if (start) begin
      shift_q  <= bin;
      bcd_q    <= '0;
      iter_q   <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      bcd_q   <= {bcd_adj[10:0], shift_q[7]};
      shift_q <= {shift_q[6:0], 1'b0};
      iter_q  <= iter_q + 4'd1;
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/disp_seg7_scan.sv
// Converts the displayed value/index to decimal and scans it onto a 4-digit panel.
module disp_seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_display,
  input  logic [7:0] value_i,
  input  logic [2:0] sel_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       dp_o,
  output logic       busy_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  state_t state_q, state_d;

  logic        valid_q;
  logic [7:0]  last_val_q;
  logic [2:0]  last_sel_q;
  logic        start;
  logic        conv_busy, conv_done;
  logic [3:0]  hundreds, tens, ones;
  logic [PW-1:0] presc_q;
  logic [1:0]  digit_q;
  logic [NUM_DIGITS-1:0][6:0] disp_q;

  assign start = (state_q == IDLE) && run_display &&
                 (!valid_q || (value_i != last_val_q) || (sel_i != last_sel_q));

  assign busy_o = conv_busy || (state_q != IDLE);

  bin2bcd_seq u_bcd (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (!run_display),
    .bin      (value_i),
    .busy     (conv_busy),
    .done     (conv_done),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: dropping run_display aborts from any state
  always_comb begin
    state_d = state_q;
    if (!run_display) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CONV;
        CONV:    if (conv_done) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Remember the pair being converted so an unchanged input is not reconverted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      last_val_q <= '0;
      last_sel_q <= '0;
    end else if (!run_display) begin
      valid_q <= 1'b0;
    end else if (start) begin
      valid_q    <= 1'b1;
      last_val_q <= value_i;
      last_sel_q <= sel_i;
    end
  end

  // Display registers hold decoded, leading-zero-blanked digit patterns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= {NUM_DIGITS{SEG_BLANK}};
    end else if (!run_display) begin
      disp_q <= {NUM_DIGITS{SEG_BLANK}};
    end else if (state_q == DONE) begin
      disp_q[3] <= seg_decode({1'b0, last_sel_q});
      disp_q[2] <= (hundreds == 4'd0) ? SEG_BLANK : seg_decode(hundreds);
      disp_q[1] <= ((hundreds == 4'd0) && (tens == 4'd0)) ? SEG_BLANK : seg_decode(tens);
      disp_q[0] <= seg_decode(ones);
    end
  end

  // Free-running prescaler advances the digit index on each wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      digit_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      digit_q <= digit_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Register segments, enables and dp together so they switch on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_o <= SEG_BLANK;
      an_o  <= 4'b1111;
      dp_o  <= 1'b0;
    end else if (!run_display) begin
      seg_o <= SEG_BLANK;
      an_o  <= 4'b1111;
      dp_o  <= 1'b0;
    end else begin
      seg_o <= disp_q[digit_q];
      an_o  <= ~(4'b0001 << digit_q);
      dp_o  <= (digit_q == 2'd3);
    end
  end

endmodule

// File: tb/tb_disp_seg7_scan.sv
// Directed self-checking bench for disp_seg7_scan with SCAN_DIV=4.
module tb_disp_seg7_scan;

  typedef logic [3:0][6:0] table_t;

  logic       clk;
  logic       reset;
  logic       run_display;
  logic [7:0] value_i;
  logic [2:0] sel_i;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       dp_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected digit tables, index = digit number (3 = result index)
  table_t t_blank, t12, t255, t0, t100, t200, t77;

  disp_seg7_scan #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .run_display (run_display),
    .value_i     (value_i),
    .sel_i       (sel_i),
    .seg_o       (seg_o),
    .an_o        (an_o),
    .dp_o        (dp_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_for_an(input table_t t, input logic [3:0] an);
    logic [6:0] r;
    r = 7'bxxxxxxx;
    case (an)
      4'b1110: r = t[0];
      4'b1101: r = t[1];
      4'b1011: r = t[2];
      4'b0111: r = t[3];
      default: r = 7'bxxxxxxx;
    endcase
    return r;
  endfunction

  // Watch one full scan period and compare every digit plus the dp placement
  task automatic scan_check(input table_t want, input string tag);
    table_t got;
    got = 'x;
    for (int i = 0; i < 16; i++) begin
      check_output({tag, " dp"}, {31'd0, dp_o}, {31'd0, (an_o == 4'b0111)});
      case (an_o)
        4'b1110: got[0] = seg_o;
        4'b1101: got[1] = seg_o;
        4'b1011: got[2] = seg_o;
        4'b0111: got[3] = seg_o;
        default: ;
      endcase
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      check_output($sformatf("%s digit%0d", tag, d), {25'd0, got[d]}, {25'd0, want[d]});
    end
  endtask

  // Start a conversion at the next edge N and check busy window and display latency
  task automatic run_conversion(input logic [7:0] v, input logic [2:0] s,
                                input table_t prev, input table_t want, input string tag);
    run_display = 1'b1;
    value_i     = v;
    sel_i       = s;
    tick();
    for (int k = 0; k < 9; k++) begin
      check_output({tag, " busy"}, {31'd0, busy_o}, 32'd1);
      tick();
    end
    check_output({tag, " busy end"}, {31'd0, busy_o}, 32'd0);
    check_output({tag, " old seg"}, {25'd0, seg_o}, {25'd0, exp_for_an(prev, an_o)});
    tick();
    check_output({tag, " new seg"}, {25'd0, seg_o}, {25'd0, exp_for_an(want, an_o)});
    scan_check(want, tag);
  endtask

  initial begin
    t_blank = {7'h00, 7'h00, 7'h00, 7'h00};
    t12     = {7'h3F, 7'h00, 7'h06, 7'h5B};
    t255    = {7'h07, 7'h5B, 7'h6D, 7'h6D};
    t0      = {7'h4F, 7'h00, 7'h00, 7'h3F};
    t100    = {7'h6D, 7'h06, 7'h3F, 7'h3F};
    t200    = {7'h3F, 7'h5B, 7'h3F, 7'h3F};
    t77     = {7'h3F, 7'h00, 7'h07, 7'h07};

    // Reset held for two edges
    reset       = 1'b0;
    run_display = 1'b0;
    value_i     = 8'd0;
    sel_i       = 3'd0;
    tick();
    tick();
    check_output("reset seg", {25'd0, seg_o}, 32'd0);
    check_output("reset an", {28'd0, an_o}, 32'hF);
    check_output("reset dp", {31'd0, dp_o}, 32'd0);
    check_output("reset busy", {31'd0, busy_o}, 32'd0);
    reset = 1'b1;
    tick();
    check_output("idle an", {28'd0, an_o}, 32'hF);
    check_output("idle busy", {31'd0, busy_o}, 32'd0);

    // Basic conversions, each starting from the previous display content
    run_conversion(8'd12,  3'd0, t_blank, t12,  "v12");
    run_conversion(8'd255, 3'd7, t12,     t255, "v255");
    run_conversion(8'd0,   3'd3, t255,    t0,   "v0");
    run_conversion(8'd100, 3'd5, t0,      t100, "v100");

    // Input change mid-conversion: 12 shown first, then 200 ten cycles later
    value_i = 8'd12;
    sel_i   = 3'd0;
    tick();
    tick();
    tick();
    value_i = 8'd200;
    for (int k = 0; k < 7; k++) tick();
    check_output("chg busy gap", {31'd0, busy_o}, 32'd0);
    tick();
    check_output("chg recapture", {31'd0, busy_o}, 32'd1);
    check_output("chg first 12", {25'd0, seg_o}, {25'd0, exp_for_an(t12, an_o)});
    for (int k = 0; k < 9; k++) tick();
    check_output("chg still 12", {25'd0, seg_o}, {25'd0, exp_for_an(t12, an_o)});
    tick();
    check_output("chg shows 200", {25'd0, seg_o}, {25'd0, exp_for_an(t200, an_o)});
    scan_check(t200, "v200");

    // Drop run_display mid-conversion, then re-raise with the same value
    value_i = 8'd77;
    tick();
    tick();
    tick();
    run_display = 1'b0;
    tick();
    check_output("drop an", {28'd0, an_o}, 32'hF);
    check_output("drop busy", {31'd0, busy_o}, 32'd0);
    check_output("drop seg", {25'd0, seg_o}, 32'd0);
    check_output("drop dp", {31'd0, dp_o}, 32'd0);
    run_conversion(8'd77, 3'd0, t_blank, t77, "rerun77");

    // Asynchronous reset mid-conversion, then scan order from digit 0
    value_i = 8'd150;
    sel_i   = 3'd2;
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check_output("async rst an", {28'd0, an_o}, 32'hF);
    check_output("async rst busy", {31'd0, busy_o}, 32'd0);
    check_output("async rst seg", {25'd0, seg_o}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_an;
      tick();
      exp_an = ~(4'b0001 << (i / 4));
      check_output($sformatf("scan an edge%0d", i + 1), {28'd0, an_o}, {28'd0, exp_an});
      if (i < 10) begin
        check_output($sformatf("no stale edge%0d", i + 1), {25'd0, seg_o}, 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/disp_seg7_scan.md
# disp_seg7_scan

Downstream consumer of the result-display stage. Takes the 8-bit value and 3-bit result index that the display stage cycles through, converts the value to decimal with a sequential double-dabble converter, and drives a time-multiplexed 4-digit seven-segment panel. Digit 3 shows the result index; digits 2..0 show the value as 0–255.

## Interface
Parameters:
- SCAN_DIV, 4: clk cycles each digit stays enabled; legal range ≥1. Board builds override it, e.g. 50000.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run_display  in  1  high while the top-level controller is in its display state.
- value_i  in  8  value currently shown by the display stage (its display_result_o).
- sel_i  in  3  index of the shown result (its state_display_o).
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-high.
- an_o  out  4  digit enables, active-low, one-hot-low; an_o[0] is the rightmost digit.
- dp_o  out  1  decimal point, active-high.
- busy_o  out  1  high while a conversion is in flight.

## Operation
- FSM states: IDLE, CONV, DONE.
  - IDLE → CONV when run_display=1 and either (value_i,sel_i) differs from the last captured pair or the capture-valid flag is 0. On that edge: latch the pair, set capture-valid, clear iteration count.
  - CONV performs 8 iterations, one per clock: add 3 to any BCD nibble ≥5, then shift left one bit with the next value MSB.
  - After the 8th iteration, CONV → DONE. DONE commits hundreds/tens/ones and the latched sel to display registers, then returns to IDLE.
- Input changes during CONV/DONE are ignored. IDLE re-compares on the next edge, so the final stable value is always converted. No value is queued.
- run_display=0 has priority over everything:
  - FSM goes to IDLE and any conversion is aborted.
  - capture-valid clears and display registers are set to blank.
  - an_o is forced to 4'b1111.
- Digit content:
  - Digit 3 shows sel as 0–7.
  - Digit 2 shows hundreds, blanked if 0.
  - Digit 1 shows tens, blanked if tens=0 and hundreds=0.
  - Digit 0 shows ones, never blanked.
- Segment codes:
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F.
  - blank=7'h00.
- dp_o=1 only while digit 3 is enabled and run_display=1. It acts as the index separator.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously after reset, independent of run_display.
  - When the prescaler wraps, the digit index increments mod 4. Order is 0,1,2,3,0...

## Timing
- Reset values: seg_o=0, an_o=4'b1111, dp_o=0, busy_o=0, FSM=IDLE, prescaler=0, digit index=0, capture-valid=0, display registers blank.
- Capture edge N. busy_o=1 from N through N+9. CONV iterations occur on edges N+1..N+8. Commit occurs on N+9. busy_o returns to 0 after N+9.
- Display latency: the new digit content appears on outputs at edge N+10, because outputs are registered one cycle after the digit index or the display registers.
- seg_o, an_o and dp_o are all registered and change on the same edge; no glitch is allowed between them.
- Full scan period is 4·SCAN_DIV cycles. With SCAN_DIV=1 the digit index advances every cycle.
- A run_display fall on any edge blanks the outputs on the next edge.
- Reset asserted mid-CONV resets asynchronously to the reset values. After reset release, no commit of the stale conversion occurs.

## Structure
- Package seg7_pkg holds:
  - FSM state typedef (IDLE/CONV/DONE).
  - NUM_DIGITS=4.
  - The ten segment constants plus SEG_BLANK.
  - BCD_ITER=8.
- Sub-module bin2bcd_seq holds the iterative double-dabble datapath: start, 8-bit bin, busy, done pulse, 3×4-bit BCD.
- The top module holds the FSM, blanking logic, scan prescaler, digit mux and segment decode.

## Test plan
- Hold reset low 2 cycles. Check all outputs at reset values, an_o=4'b1111, and no conversion started.
- run_display=1, value_i=12, sel_i=0 at edge N:
  - busy_o is high N..N+9.
  - From N+10 the scan shows digit3=7'h3F, digit2=blank, digit1=7'h06, digit0=7'h5B.
  - dp_o is high only on digit 3.
- value_i=255, sel_i=7 → digits 7'h07, 7'h5B, 7'h6D, 7'h6D. value_i=0 → blank, blank, 7'h3F. value_i=100 → tens shows 7'h3F, not blanked.
- value_i changes 12→200 at N+3 during CONV:
  - The display first shows 12 at N+10.
  - A second conversion captures 200 at N+10 and shows it at N+20.
- Drop run_display mid-CONV:
  - an_o=4'b1111 next edge and busy_o=0.
  - Re-raise with an unchanged value_i → a conversion starts anyway because capture-valid was cleared.
- SCAN_DIV=4: each an_o pattern lasts exactly 4 cycles in order 1110, 1101, 1011, 0111. Assert reset mid-scan → index restarts at digit 0.
